// File: rtl/unidade_de_entrada.sv
// rtl/unidade_de_entrada.sv - IN/OUT peripheral responder: debounced button confirms switch input, OUT latches display
//
// Ports:
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   inReq     IN instruction in execute
//   outWrite  OUT instruction strobe
//   outData   value to display
//   btnRaw    raw confirm button (asynchronous, active-high)
//   swRaw     raw data switches (asynchronous)
//   inAck     one-cycle acknowledge per accepted input
//   dataIn    latched input word (zero-extended switches)
//   display   last OUT value
//   outCount  number of OUT writes since reset, wraps at 256
//   busy      high while an input is armed, acknowledged or awaiting release
module unidade_de_entrada #(
    parameter int DATA_WIDTH = 32,
    parameter int SW_WIDTH   = 16,
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_WIDTH  = 18
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  inReq,
    input  logic                  outWrite,
    input  logic [DATA_WIDTH-1:0] outData,
    input  logic                  btnRaw,
    input  logic [SW_WIDTH-1:0]   swRaw,
    output logic                  inAck,
    output logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] display,
    output logic [7:0]            outCount,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                 btn_s1, btn_s2;
    logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
    logic [CNT_WIDTH-1:0] deb_cnt;
    logic                 btn_db;
    logic                 btn_db_d;
    logic                 press_edge;

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btnRaw;
            btn_s2 <= btn_s1;
            sw_s1  <= swRaw;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: the counter only runs while the synchronized level disagrees
    // with the accepted level, so any agreeing sample restarts the count and
    // glitches shorter than DEB_CYCLES are discarded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt <= '0;
            btn_db  <= 1'b0;
        end else if (btn_s2 == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_WIDTH'(DEB_CYCLES - 1)) begin
            deb_cnt <= '0;
            btn_db  <= ~btn_db;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Registered rising-edge detect on the debounced level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_db_d   <= 1'b0;
            press_edge <= 1'b0;
        end else begin
            btn_db_d   <= btn_db;
            press_edge <= btn_db & ~btn_db_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A press already held when the request arrives produced its edge earlier,
    // so ARMED waits for a fresh press: one press is one accepted input.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (inReq) state_nxt = ARMED;
            ARMED: begin
                if (!inReq)          state_nxt = IDLE;
                else if (press_edge) state_nxt = ACK;
            end
            ACK:     state_nxt = btn_db ? RELEASE : IDLE;
            RELEASE: if (!btn_db) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dataIn <= '0;
        end else if (state == ARMED && inReq && press_edge) begin
            dataIn <= DATA_WIDTH'(sw_s2);
        end
    end

    // OUT capture runs independently of the input handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            display  <= '0;
            outCount <= 8'd0;
        end else if (outWrite) begin
            display  <= outData;
            outCount <= outCount + 8'd1;
        end
    end

    assign inAck = (state == ACK);
    assign busy  = (state != IDLE);

endmodule
